// File: rtl/y86_fetch_decode_execute.sv
// y86_fetch_decode_execute
// Front half of a single-cycle Y86-64 SEQ core: fetch from an internal byte-addressed
// instruction memory, decode with register-file read/write-back, and execute with ALU
// and condition codes. All datapath outputs are combinational from PC, valM, memory
// contents and current state; the register file and CC update on posedge clk.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   PC, valM                current instruction address, memory-stage read data
//   imem_we/waddr/wdata     synchronous byte write port for loading instruction memory
//   icode, ifun, rA, rB     decoded instruction fields
//   valC, valP              constant word, address of next sequential instruction
//   halt, instructionValid, imemError   status
//   valA, valB, valE, cnd   operands, ALU result, condition result
//   register0..register14   register-file contents (%rax..%r14)
module y86_fetch_decode_execute #(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PC,
  input  logic [63:0] valM,
  input  logic        imem_we,
  input  logic [9:0]  imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        halt,
  output logic        instructionValid,
  output logic        imemError,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        cnd,
  output logic [63:0] register0,
  output logic [63:0] register1,
  output logic [63:0] register2,
  output logic [63:0] register3,
  output logic [63:0] register4,
  output logic [63:0] register5,
  output logic [63:0] register6,
  output logic [63:0] register7,
  output logic [63:0] register8,
  output logic [63:0] register9,
  output logic [63:0] register10,
  output logic [63:0] register11,
  output logic [63:0] register12,
  output logic [63:0] register13,
  output logic [63:0] register14
);

  localparam int unsigned AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IRrmovq = 4'h2;
  localparam logic [3:0] IIrmovq = 4'h3;
  localparam logic [3:0] IRmmovq = 4'h4;
  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPushq  = 4'hA;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;
  localparam logic [3:0] RRsp    = 4'h4;

  // ---------------------------------------------------------------------------
  // Instruction memory (load port has no reset dependence)
  // ---------------------------------------------------------------------------
  logic [7:0]    imem [IMEM_BYTES];
  logic [AW-1:0] waddr_idx;

  assign waddr_idx = AW'(imem_waddr);

  always_ff @(posedge clk) begin
    if (imem_we && (32'(imem_waddr) < IMEM_BYTES)) begin
      imem[waddr_idx] <= imem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch: up to 10 bytes starting at PC; out-of-range bytes read as zero
  // ---------------------------------------------------------------------------
  logic [7:0] fbyte [10];

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      logic [64:0] a;
      a = {1'b0, PC} + 65'(i);
      if (a < 65'(IMEM_BYTES)) fbyte[i] = imem[a[AW-1:0]];
      else                     fbyte[i] = 8'h00;
    end
  end

  logic       need_regids;
  logic [3:0] ilen;

  assign icode = fbyte[0][7:4];
  assign ifun  = fbyte[0][3:0];

  always_comb begin
    need_regids = 1'b0;
    valC        = '0;
    ilen        = 4'd1;
    case (icode)
      IRrmovq, IOpq, IPushq, IPopq: begin
        need_regids = 1'b1;
        ilen        = 4'd2;
      end
      IIrmovq, IRmmovq, IMrmovq: begin
        need_regids = 1'b1;
        ilen        = 4'd10;
        valC        = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                       fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
      end
      IJxx, ICall: begin
        ilen = 4'd9;
        valC = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
      end
      default: ;
    endcase
  end

  assign rA   = need_regids ? fbyte[1][7:4] : RNone;
  assign rB   = need_regids ? fbyte[1][3:0] : RNone;
  assign valP = PC + 64'(ilen);

  // Widened so a PC near the top of the address space cannot wrap below the limit.
  assign imemError = (({1'b0, PC} + 65'(ilen)) > 65'(IMEM_BYTES));

  always_comb begin
    instructionValid = 1'b1;
    case (icode)
      IRrmovq, IJxx: if (ifun > 4'd6) instructionValid = 1'b0;
      IOpq:          if (ifun > 4'd3) instructionValid = 1'b0;
      IHalt, INop, IIrmovq, IRmmovq, IMrmovq, ICall, IRet, IPushq, IPopq:
                     if (ifun != 4'd0) instructionValid = 1'b0;
      default:       instructionValid = 1'b0;
    endcase
  end

  assign halt = (icode == IHalt) && instructionValid && !imemError;

  // ---------------------------------------------------------------------------
  // Decode: register-file read
  // ---------------------------------------------------------------------------
  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  logic        zf_q, sf_q, of_q;
  logic        zf_d, sf_d, of_d;
  logic [3:0]  src_a, src_b, dst_e, dst_m;

  always_comb begin
    src_a = RNone;
    src_b = RNone;
    case (icode)
      IRrmovq, IRmmovq, IOpq, IPushq: src_a = rA;
      IRet, IPopq:                    src_a = RRsp;
      default: ;
    endcase
    case (icode)
      IRmmovq, IMrmovq, IOpq:      src_b = rB;
      ICall, IRet, IPushq, IPopq:  src_b = RRsp;
      default: ;
    endcase
  end

  // Register F is "none" and reads as zero.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a == 4'(i)) valA = rf_q[i];
      if (src_b == 4'(i)) valB = rf_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Execute: ALU, new condition codes, branch/move condition from stored CC
  // ---------------------------------------------------------------------------
  logic [63:0] alu_a, alu_b;
  logic [1:0]  alu_fun;
  logic        alu_of;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode)
      IRrmovq, IOpq:              alu_a = valA;
      IIrmovq, IRmmovq, IMrmovq:  alu_a = valC;
      ICall, IPushq:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      IRet, IPopq:                alu_a = 64'd8;
      default: ;
    endcase
    case (icode)
      IRmmovq, IMrmovq, IOpq, ICall, IRet, IPushq, IPopq: alu_b = valB;
      default: ;
    endcase
  end

  assign alu_fun = (icode == IOpq) ? ifun[1:0] : 2'd0;

  always_comb begin
    valE   = '0;
    alu_of = 1'b0;
    case (alu_fun)
      2'd0: begin
        valE   = alu_b + alu_a;
        alu_of = (alu_a[63] == alu_b[63]) && (valE[63] != alu_a[63]);
      end
      2'd1: begin
        valE   = alu_b - alu_a;
        alu_of = (alu_a[63] != alu_b[63]) && (valE[63] != alu_b[63]);
      end
      2'd2: valE = alu_a & alu_b;
      2'd3: valE = alu_a ^ alu_b;
      default: ;
    endcase
  end

  always_comb begin
    cnd = 1'b0;
    if ((icode == IRrmovq) || (icode == IJxx)) begin
      case (ifun)
        4'd0: cnd = 1'b1;
        4'd1: cnd = (sf_q ^ of_q) | zf_q;
        4'd2: cnd = sf_q ^ of_q;
        4'd3: cnd = zf_q;
        4'd4: cnd = ~zf_q;
        4'd5: cnd = ~(sf_q ^ of_q);
        4'd6: cnd = ~(sf_q ^ of_q) & ~zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back and CC next state
  // ---------------------------------------------------------------------------
  logic commit;

  assign commit = !halt && !imemError && instructionValid;

  always_comb begin
    dst_e = RNone;
    dst_m = RNone;
    case (icode)
      IRrmovq:                    if (cnd) dst_e = rB;
      IIrmovq, IOpq:              dst_e = rB;
      ICall, IRet, IPushq, IPopq: dst_e = RRsp;
      default: ;
    endcase
    if ((icode == IMrmovq) || (icode == IPopq)) dst_m = rA;
  end

  // M port is checked first so popq %rsp leaves the loaded value in %rsp.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (commit && (dst_m == 4'(i)))      rf_d[i] = valM;
      else if (commit && (dst_e == 4'(i))) rf_d[i] = valE;
    end
  end

  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (commit && (icode == IOpq)) begin
      zf_d = (valE == 64'd0);
      sf_d = valE[63];
      of_d = alu_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) rf_q[i] <= rf_d[i];
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign register0  = rf_q[0];
  assign register1  = rf_q[1];
  assign register2  = rf_q[2];
  assign register3  = rf_q[3];
  assign register4  = rf_q[4];
  assign register5  = rf_q[5];
  assign register6  = rf_q[6];
  assign register7  = rf_q[7];
  assign register8  = rf_q[8];
  assign register9  = rf_q[9];
  assign register10 = rf_q[10];
  assign register11 = rf_q[11];
  assign register12 = rf_q[12];
  assign register13 = rf_q[13];
  assign register14 = rf_q[14];

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Directed bench for y86_fetch_decode_execute: loads a small program with the
// DUT held in reset, then steps PC through it and checks fields, datapath
// values and register/CC effects against hand-computed expectations.
module tb_y86_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] PC, valM;
  logic        imem_we;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        halt, instructionValid, imemError, cnd;
  logic [63:0] register0, register1, register2, register3, register4;
  logic [63:0] register5, register6, register7, register8, register9;
  logic [63:0] register10, register11, register12, register13, register14;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  y86_fetch_decode_execute #(.IMEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .valM(valM),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .halt(halt), .instructionValid(instructionValid), .imemError(imemError),
    .valA(valA), .valB(valB), .valE(valE), .cnd(cnd),
    .register0(register0), .register1(register1), .register2(register2),
    .register3(register3), .register4(register4), .register5(register5),
    .register6(register6), .register7(register7), .register8(register8),
    .register9(register9), .register10(register10), .register11(register11),
    .register12(register12), .register13(register13), .register14(register14)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input int addr, input logic [7:0] b);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = 10'(addr);
    imem_wdata = b;
    @(posedge clk);
    #1 imem_we = 1'b0;
  endtask

  task automatic put_irmovq(input int addr, input logic [3:0] rb, input logic [63:0] v);
    put(addr, 8'h30);
    put(addr + 1, {4'hF, rb});
    for (int k = 0; k < 8; k++) put(addr + 2 + k, v[8*k +: 8]);
  endtask

  task automatic put_jxx(input int addr, input logic [3:0] fn, input logic [63:0] dest);
    put(addr, {4'h7, fn});
    for (int k = 0; k < 8; k++) put(addr + 1 + k, dest[8*k +: 8]);
  endtask

  // Present a new PC mid-cycle and let the combinational path settle.
  task automatic at_pc(input logic [63:0] pc);
    @(negedge clk);
    PC = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; PC = '0; valM = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    // Program image
    put_irmovq(0, 4'h0, 64'd10);            // irmovq $10,%rax
    put_irmovq(10, 4'h3, 64'd3);            // irmovq $3,%rbx
    put(20, 8'h61); put(21, 8'h03);         // subq %rax,%rbx
    put_jxx(22, 4'h2, 64'h100);             // jl 0x100
    put_irmovq(31, 4'h4, 64'd64);           // irmovq $64,%rsp
    put_irmovq(41, 4'h0, 64'd5);            // irmovq $5,%rax
    put(51, 8'hA0); put(52, 8'h0F);         // pushq %rax
    put(53, 8'hB0); put(54, 8'h4F);         // popq %rsp
    put(55, 8'h24); put(56, 8'h01);         // cmovne %rax,%rcx
    put(57, 8'h00);                         // halt
    put(58, 8'hC0);                         // illegal icode
    put_jxx(59, 4'h3, 64'h200);             // je 0x200
    put(68, 8'h63); put(69, 8'h66);         // xorq %rsi,%rsi
    put(70, 8'h62); put(71, 8'h03);         // andq %rax,%rbx
    put(72, 8'h67); put(73, 8'h03);         // opq ifun 7 (illegal)
    put(1020, 8'h30); put(1021, 8'hF0); put(1022, 8'h77); put(1023, 8'h00);

    // Reset state
    at_pc(59);
    chk("rst_je_zf", 64'(cnd), 64'd1);
    chk("rst_rax", register0, 64'd0);
    chk("rst_rsp", register4, 64'd0);
    at_pc(0); tick();
    chk("rst_blocks_wr", register0, 64'd0);

    @(negedge clk); rst_n = 1'b1;

    // irmovq $10,%rax
    at_pc(0);
    chk("irm_icode", 64'(icode), 64'd3);
    chk("irm_rA", 64'(rA), 64'hF);
    chk("irm_rB", 64'(rB), 64'd0);
    chk("irm_valC", valC, 64'd10);
    chk("irm_valP", valP, 64'd10);
    chk("irm_valE", valE, 64'd10);
    chk("irm_valid", 64'(instructionValid), 64'd1);
    chk("irm_memerr", 64'(imemError), 64'd0);
    chk("irm_halt", 64'(halt), 64'd0);
    tick();
    chk("irm_rax", register0, 64'd10);

    at_pc(10); tick();
    chk("irm_rbx", register3, 64'd3);

    // subq %rax,%rbx : 3 - 10 = -7
    at_pc(20);
    chk("sub_valA", valA, 64'd10);
    chk("sub_valB", valB, 64'd3);
    chk("sub_valE", valE, 64'hFFFF_FFFF_FFFF_FFF9);
    tick();
    chk("sub_rbx", register3, 64'hFFFF_FFFF_FFFF_FFF9);

    // jl taken on SF=1, je not taken on ZF=0
    at_pc(22);
    chk("jl_icode", 64'(icode), 64'd7);
    chk("jl_valC", valC, 64'h100);
    chk("jl_valP", valP, 64'd31);
    chk("jl_cnd", 64'(cnd), 64'd1);
    at_pc(59);
    chk("je_cnd", 64'(cnd), 64'd0);

    at_pc(31); tick();
    chk("rsp64", register4, 64'd64);
    at_pc(41); tick();
    chk("rax5", register0, 64'd5);

    // pushq %rax
    at_pc(51);
    chk("push_valA", valA, 64'd5);
    chk("push_valB", valB, 64'd64);
    chk("push_valE", valE, 64'd56);
    tick();
    chk("push_rsp", register4, 64'd56);

    // popq %rsp: M write wins over E
    at_pc(53); valM = 64'd99; #1;
    chk("pop_valE", valE, 64'd64);
    tick();
    chk("pop_rsp", register4, 64'd99);
    valM = '0;

    // xorq %rsi,%rsi -> ZF=1
    at_pc(68);
    chk("xor_valE", valE, 64'd0);
    tick();

    at_pc(55);
    chk("cmovne_z_cnd", 64'(cnd), 64'd0);
    tick();
    chk("cmovne_z_rcx", register1, 64'd0);

    // subq again: -7 - 5 = -12 -> ZF=0
    at_pc(20);
    chk("sub2_valE", valE, 64'hFFFF_FFFF_FFFF_FFF4);
    tick();

    at_pc(55);
    chk("cmovne_nz_cnd", 64'(cnd), 64'd1);
    chk("cmovne_valE", valE, 64'd5);
    tick();
    chk("cmovne_rcx", register1, 64'd5);

    // andq %rax,%rbx : 5 & 0x..F4 = 4
    at_pc(70);
    chk("and_valE", valE, 64'd4);
    tick();
    chk("and_rbx", register3, 64'd4);

    at_pc(57);
    chk("halt", 64'(halt), 64'd1);
    chk("halt_valP", valP, 64'd58);
    tick();
    chk("halt_rsp", register4, 64'd99);

    at_pc(58);
    chk("c0_valid", 64'(instructionValid), 64'd0);

    at_pc(72);
    chk("op7_valid", 64'(instructionValid), 64'd0);
    tick();
    chk("op7_nowr", register3, 64'd4);

    at_pc(1020);
    chk("memerr", 64'(imemError), 64'd1);
    chk("memerr_valC", valC, 64'h77);
    tick();
    chk("memerr_nowr", register0, 64'd5);

    // Asynchronous reset mid-cycle
    at_pc(0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rax", register0, 64'd0);
    chk("arst_rcx", register1, 64'd0);
    chk("arst_rbx", register3, 64'd0);
    chk("arst_rsp", register4, 64'd0);
    at_pc(59);
    chk("arst_zf", 64'(cnd), 64'd1);
    at_pc(0); tick();
    chk("arst_hold", register0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
